// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer: parallel-to-serial front end for a 16:1 mux tree.
// A 16-bit word is held on mux_in while mux_sel walks all 16 positions; the
// mux output is forwarded unregistered as a serial bitstream with
// valid/ready/last. A one-word skid buffer allows back-to-back words.
module mux_scan_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  output logic [15:0] mux_in,
  output logic [3:0]  mux_sel,
  input  logic        mux_out,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        ser_data,
  output logic        ser_last,
  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] act_q, act_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;

  logic load_acc;
  logic bit_xfer;
  logic last_bit;

  assign load_ready = !pend_v_q;
  assign load_acc   = load_valid && load_ready;
  assign ser_valid  = (state_q == SHIFT);
  assign bit_xfer   = ser_valid && ser_ready;
  assign last_bit   = (cnt_q == 4'd15);

  // The only combinational path through the block: mux_out -> ser_data.
  assign ser_data = mux_out;
  assign ser_last = ser_valid && last_bit;
  assign mux_in   = act_q;
  assign mux_sel  = MSB_FIRST ? ~cnt_q : cnt_q;
  assign busy     = (state_q == SHIFT) || pend_v_q;

  // Next-state: load/skid handling and bit-index stepping.
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    unique case (state_q)
      IDLE: begin
        if (load_acc) begin
          act_d   = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_xfer && last_bit) begin
          // Last bit leaves this cycle: refill act from the skid first, else
          // take a word arriving right now, else fall back to IDLE. A load
          // cannot coincide with pend_v=1 because load_ready is low then.
          if (pend_v_q) begin
            act_d    = pend_q;
            pend_v_d = 1'b0;
            cnt_d    = '0;
          end else if (load_acc) begin
            act_d = load_data;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          if (bit_xfer) begin
            cnt_d = cnt_q + 4'd1;
          end
          if (load_acc) begin
            pend_d   = load_data;
            pend_v_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      act_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

endmodule

// File: doc/mux_scan_serializer.md
# mux_scan_serializer

Parallel-to-serial front end for the 16:1 mux tree. It accepts 16-bit words over a valid/ready handshake and presents each word on the mux data inputs. It steps the mux select through all 16 positions and forwards the mux output as a serial bitstream with its own valid/ready/last handshake. A one-word skid buffer allows back-to-back words with no idle cycle between them.

## Interface
- MSB_FIRST, 0, 0: bit 0 is sent first (mux_sel counts 0→15); 1: bit 15 is sent first (mux_sel counts 15→0).
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_valid  input  1  load_data is valid
- load_ready  output  1  block can accept a word
- load_data  input  16  word to serialize
- mux_in  output  16  active word, wired to the mux data input
- mux_sel  output  4  bit select, wired to the mux select
- mux_out  input  1  mux output; a combinational function of mux_in[mux_sel]
- ser_valid  output  1  ser_data is valid
- ser_ready  input  1  downstream accepts a bit
- ser_data  output  1  serial bit, equal to mux_out
- ser_last  output  1  marks the 16th bit of a word
- busy  output  1  a word is active or pending

## Operation
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Registers:
  - act[15:0]: active word; drives mux_in.
  - cnt[3:0]: bit index.
  - pend[15:0] and pend_v: skid buffer.
  - state: IDLE or SHIFT.
- Output decode:
  - mux_sel = cnt when MSB_FIRST=0; ~cnt when MSB_FIRST=1.
  - ser_valid = (state==SHIFT).
  - ser_data = mux_out, passed through with no register.
  - ser_last = ser_valid && cnt==15.
  - load_ready = !pend_v.
  - busy = (state==SHIFT) || pend_v.
- Load accepted (load_valid && load_ready):
  - In IDLE, or in the same cycle as the last-bit transfer: act←load_data, cnt←0, state←SHIFT.
  - In SHIFT otherwise: pend←load_data, pend_v←1.
- Bit transfer (ser_valid && ser_ready):
  - cnt<15: cnt←cnt+1.
  - cnt==15 and pend_v=1: act←pend, pend_v←0, cnt←0, stay in SHIFT.
  - cnt==15, pend_v=0, load accepted the same cycle: direct load as above.
  - cnt==15, no word waiting: state←IDLE, cnt←0. act keeps its value.
- Stall: while ser_valid && !ser_ready, act, cnt and mux_sel hold, so ser_data is stable.
- Reset (asynchronous, usable at any time, including mid-word):
  - state=IDLE, cnt=0, act=0, pend=0, pend_v=0.
  - Outputs: mux_in=0, mux_sel=0 (15 when MSB_FIRST=1), ser_valid=0, ser_last=0, load_ready=1, busy=0.
  - A partially sent word and any pending word are discarded.
- The block never drops or duplicates a bit. Each accepted word produces exactly 16 transfers, the last one flagged by ser_last.

## Timing
- Load accepted at edge N (from IDLE): first bit appears with ser_valid=1 in the cycle after edge N.
- Throughput: 1 bit per cycle while ser_ready=1. A word takes 16 cycles.
- Back-to-back words have no bubble when the next word is pending, or is loaded in the same cycle as the last-bit transfer.
- load_ready goes low the cycle after pend is filled. It goes high the cycle after pend moves into act.
- The only combinational path through the block is mux_out→ser_data. The path mux_sel→mux_out→ser_data must fit in one clock period.
- Deassertion of rst_n is synchronous to clk externally. The first accepted load is allowed on the first edge after deassertion.

## Test plan
- Single word, LSB first: load 16'hA5C3 with ser_ready=1 → ser_data = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. ser_last high only on the 16th bit. Back to IDLE with busy=0 the following cycle.
- MSB_FIRST=1: load 16'h8001 → first bit 1, then 14 zeros, last bit 1. mux_sel runs 15→0.
- Back-to-back: load 16'hFFFF, then 16'h0000 while the first word is shifting → 32 consecutive ser_valid cycles with no gap. ser_last on cycles 16 and 32. load_ready is low while pend holds the second word.
- Backpressure: word 16'h00F0; hold ser_ready=0 for 5 cycles at bit 4 → ser_data=1 and mux_sel=4 stay stable through the stall. All 16 bits are still delivered in order.
- Skid full: hold load_valid=1 with three different words → the third word is accepted only after the first word's ser_last transfer. The output order matches the load order.
- Reset mid-word: assert rst_n=0 asynchronously at bit 7 with a word pending → all outputs reach their reset values immediately. After release, a new load 16'h0001 serializes cleanly from bit 0.
